// File: rtl/alu_arbiter_pkg.sv
// Shared types for the ALU arbiter slice: the ALU opcode encoding and requester limits.
// Opcodes occupy 0..15 of a 5-bit field; the remaining encodings are illegal and evaluate to 0.
package alu_arbiter_pkg;

  localparam int unsigned ALU_ARB_MAX_REQ = 4;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0,
    ALU_SUB = 5'd1,
    ALU_AND = 5'd2,
    ALU_OR  = 5'd3,
    ALU_XOR = 5'd4,
    ALU_SLL = 5'd5,
    ALU_SRL = 5'd6,
    ALU_SRA = 5'd7,
    ALU_LT  = 5'd8,
    ALU_LTU = 5'd9,
    ALU_GE  = 5'd10,
    ALU_GEU = 5'd11,
    ALU_EQ  = 5'd12,
    ALU_NE  = 5'd13,
    ALU_IMM = 5'd14,
    ALU_PC4 = 5'd15
  } alu_operation_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and the shared-ALU arbiter.
interface alu_arbiter_if #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned TAG_WIDTH = 4
);
  import alu_arbiter_pkg::*;

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  alu_operation_t       req_op  [NUM_REQ];
  logic [31:0]          req_lhs [NUM_REQ];
  logic [31:0]          req_rhs [NUM_REQ];
  logic [TAG_WIDTH-1:0] req_tag [NUM_REQ];
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [NUM_REQ-1:0]   rsp_ready;
  logic [31:0]          rsp_result;
  logic [TAG_WIDTH-1:0] rsp_tag;

  modport master (
    output req_valid, req_op, req_lhs, req_rhs, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_tag
  );

  modport slave (
    input  req_valid, req_op, req_lhs, req_rhs, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_tag
  );

endinterface

// File: rtl/alu.sv
// Shared 32-bit combinational ALU; illegal opcodes produce zero.
module alu
  import alu_arbiter_pkg::*;
(
  input  alu_operation_t op_i,
  input  logic [31:0]    lhs_i,
  input  logic [31:0]    rhs_i,
  output logic [31:0]    result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD: result_o = lhs_i + rhs_i;
      ALU_SUB: result_o = lhs_i - rhs_i;
      ALU_AND: result_o = lhs_i & rhs_i;
      ALU_OR:  result_o = lhs_i | rhs_i;
      ALU_XOR: result_o = lhs_i ^ rhs_i;
      ALU_SLL: result_o = lhs_i << rhs_i[4:0];
      ALU_SRL: result_o = lhs_i >> rhs_i[4:0];
      ALU_SRA: result_o = $signed(lhs_i) >>> rhs_i[4:0];
      ALU_LT:  result_o = {31'd0, $signed(lhs_i) < $signed(rhs_i)};
      ALU_LTU: result_o = {31'd0, lhs_i < rhs_i};
      ALU_GE:  result_o = {31'd0, $signed(lhs_i) >= $signed(rhs_i)};
      ALU_GEU: result_o = {31'd0, lhs_i >= rhs_i};
      ALU_EQ:  result_o = {31'd0, lhs_i == rhs_i};
      ALU_NE:  result_o = {31'd0, lhs_i != rhs_i};
      ALU_IMM: result_o = rhs_i;
      ALU_PC4: result_o = lhs_i + 32'd4;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o
);

  logic found;

  // First pass covers [ptr, N), second pass wraps to [0, ptr).
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i] && (i >= 32'(ptr_i))) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req_i[i]) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between NUM_REQ requesters with round-robin grant and a single registered
// response stage that returns result and tag only to the issuing requester.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  alu_arbiter_if.slave bus
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                 full_q,   full_d;
  logic [31:0]          result_q, result_d;
  logic [TAG_WIDTH-1:0] tag_q,    tag_d;
  logic [NUM_REQ-1:0]   owner_q,  owner_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [NUM_REQ-1:0]   grant;
  logic                 consume;
  logic                 stage_free;
  logic                 accept;
  alu_operation_t       alu_op;
  logic [31:0]          alu_lhs;
  logic [31:0]          alu_rhs;
  logic [31:0]          alu_result;
  logic [TAG_WIDTH-1:0] grant_tag;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req_i   (bus.req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant)
  );

  alu u_alu (
    .op_i     (alu_op),
    .lhs_i    (alu_lhs),
    .rhs_i    (alu_rhs),
    .result_o (alu_result)
  );

  // Owner is kept one-hot so consume and rsp_valid need no index decode;
  // reset_n gates the grant so req_ready stays low while reset is held.
  always_comb begin
    consume    = full_q && |(owner_q & bus.rsp_ready);
    stage_free = reset_n && (!full_q || consume);
    grant      = stage_free ? arb_grant : '0;
    accept     = |grant;

    alu_op    = ALU_ADD;
    alu_lhs   = '0;
    alu_rhs   = '0;
    grant_tag = '0;
    rr_ptr_d  = rr_ptr_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        alu_op    = bus.req_op[i];
        alu_lhs   = bus.req_lhs[i];
        alu_rhs   = bus.req_rhs[i];
        grant_tag = bus.req_tag[i];
        rr_ptr_d  = PTR_W'((i + 1) % NUM_REQ);
      end
    end

    full_d   = full_q;
    result_d = result_q;
    tag_d    = tag_q;
    owner_d  = owner_q;
    if (accept) begin
      full_d   = 1'b1;
      result_d = alu_result;
      tag_d    = grant_tag;
      owner_d  = grant;
    end else if (consume) begin
      full_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q   <= 1'b0;
      result_q <= '0;
      tag_q    <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      full_q   <= full_d;
      result_q <= result_d;
      tag_q    <= tag_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.rsp_valid  = full_q ? owner_q : '0;
  assign bus.rsp_result = result_q;
  assign bus.rsp_tag    = tag_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `alu` instance between `NUM_REQ` requesters (e.g. execute stage and branch/address unit) using round-robin arbitration with valid/ready handshakes on both request and response sides. Accepted operations are evaluated combinationally by the ALU and captured in a single registered output stage. The response is returned, with its tag, only to the requester that issued the operation. The block sits between issue logic and the shared ALU datapath.

## Interface
- `NUM_REQ`, 2: number of requesters, 1..4.
- `TAG_WIDTH`, 4: width of the opaque request tag returned with the result.
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_REQ  per-requester request valid.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit high.
- `req_op`  in  NUM_REQ x alu_operation_t  operation per requester.
- `req_lhs`, `req_rhs`  in  NUM_REQ x 32  operands per requester.
- `req_tag`  in  NUM_REQ x TAG_WIDTH  tag per requester.
- `rsp_valid`  out  NUM_REQ  one-hot: response pending for that requester.
- `rsp_ready`  in  NUM_REQ  per-requester response consume.
- `rsp_result`  out  32  shared result bus; meaningful only while some `rsp_valid` bit is high.
- `rsp_tag`  out  TAG_WIDTH  shared tag bus, returned with the result.

## Operation
- Output stage states:
  - EMPTY: no pending response.
  - FULL: holds `result`, `tag`, `owner`.
- Stage is free when EMPTY, or when FULL and `rsp_ready[owner]` is high in the same cycle.
- When free:
  - Grant the first requester with `req_valid` high, searching from `rr_ptr` upward modulo NUM_REQ.
  - Assert `req_ready[grant]`.
  - ALU inputs are muxed from the granted requester.
- Handshake on `req_valid[i] & req_ready[i]`:
  - Capture ALU result, `req_tag[i]` and owner i.
  - Go to FULL.
  - Set `rr_ptr` to (i+1) mod NUM_REQ.
- FULL with `rsp_ready[owner]` and no new grant: go to EMPTY.
- FULL with no consume: the stored result, tag and owner hold stable. All `req_ready` bits are 0.
- `rsp_ready` bits of non-owners are ignored.
- `req_ready` may depend combinationally on `req_valid` and `rsp_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- Once asserted, a request must hold its valid and payload until accepted.
- Arithmetic is exactly the ALU's. An undefined `alu_operation_t` encoding returns 0.
- With NUM_REQ=1, `rr_ptr` is constant 0.

## Timing
- Reset values: `rsp_valid`=0, `req_ready`=0, `rsp_result`=0, `rsp_tag`=0, `rr_ptr`=0, stage EMPTY.
- Latency: request accepted at edge k gives `rsp_valid[i]`=1 in the cycle after edge k.
- Throughput: one op per cycle while owners consume immediately (simultaneous consume and accept).
- A blocked response stalls all requesters. No bypass.
- Fairness: a continuously valid requester is granted within NUM_REQ accepts.
- Asserting `reset_n` low mid-operation discards the pending response immediately, with no output glitch to a valid state.

## Structure
- `alu_operation_t` stays in the shared `types.sv`.
- Add `ALU_ARB_MAX_REQ = 4` there.
- Natural sub-module: `rr_arbiter` (request vector and pointer in, one-hot grant out, purely combinational).
- Pointer update stays in `alu_arbiter`.
- Instantiate the existing `alu` once.
- The stage state is a single `full` flop; no enum needed.

## Test plan
- **Reset:** assert `reset_n`=0 with all inputs active -> all outputs 0. Release, then req0 ADD 5+7 tag 3 -> next cycle `rsp_valid`=01, result 12, tag 3.
- **Round-robin:** both requesters valid continuously; req0 SUB 10-3, req1 SLL 1<<4, `rsp_ready`=11 -> grants alternate 0,1,0,1 and results alternate 7,16 every cycle.
- **Backpressure:** req1 SRA 0x80000000>>>4, `rsp_ready[1]`=0 for 5 cycles -> result 0xF8000000 held stable and `req_ready`=00 throughout. On consume, the pending req0 is granted the same cycle.
- **Non-owner ready ignored:** owner req0 holds LT -1<1, `rsp_ready`=10 -> response stays valid with result 1 until `rsp_ready[0]`=1.
- **Full opcode sweep:** all 16 ops, including GEU 0xFFFFFFFF>=1 -> 1, IMM rhs 0x1234 -> 0x1234, PC4 lhs 0x100 -> 0x104. Then an illegal encoding -> 0.
- **Reset mid-operation:** `reset_n` low while FULL with `rsp_ready`=0 -> `rsp_valid` drops asynchronously and nothing is delivered after release. The first post-reset grant goes to req0.
